// File: rtl/pps_slave_timestamper_pkg.sv
`default_nettype none
//==============================================================================
// pps_slave_timestamper_pkg : shared time constants, time record and PPS FSM states
// Revision: 1.0
//==============================================================================
package pps_slave_timestamper_pkg;

   localparam int unsigned NanosInSecond_Con   = 1000000000;
   localparam int          SecondWidth_Con     = 32;
   localparam int          NanosecondWidth_Con = 32;

   typedef struct packed {
      logic [SecondWidth_Con-1:0]     second;
      logic [NanosecondWidth_Con-1:0] nanosecond;
   } ClockTime_Type;

   typedef enum logic [1:0] {
      Idle_St     = 2'd0,
      WaitEdge_St = 2'd1,
      High_St     = 2'd2
   } PpsState_Type;

endpackage
`default_nettype wire

// File: rtl/pps_time_subtract.sv
`default_nettype none
//==============================================================================
// pps_time_subtract : registered (second, nanosecond) minus a ns delay, with borrow
// Revision: 1.0
//==============================================================================
module pps_time_subtract
   import pps_slave_timestamper_pkg::*;
(
   input  logic                           SysClk_ClkIn,
   input  logic                           SysRst_RstIn,
   input  logic                           Load_EnaIn,
   input  ClockTime_Type                  Time_DatIn,
   input  logic [NanosecondWidth_Con-1:0] Delay_DatIn,
   output ClockTime_Type                  Time_DatOut
);

   ClockTime_Type w_diff;
   ClockTime_Type r_result;

   // Delay is always below one second, so at most a single borrow is needed.
   always_comb begin
      w_diff = Time_DatIn;
      if (Time_DatIn.nanosecond >= Delay_DatIn) begin
         w_diff.nanosecond = Time_DatIn.nanosecond - Delay_DatIn;
      end else begin
         w_diff.nanosecond = Time_DatIn.nanosecond
                           + NanosecondWidth_Con'(NanosInSecond_Con) - Delay_DatIn;
         w_diff.second     = Time_DatIn.second - SecondWidth_Con'(1);
      end
   end

   always_ff @(posedge SysClk_ClkIn) begin
      if (SysRst_RstIn) begin
         r_result <= '0;
      end else if (Load_EnaIn) begin
         r_result <= w_diff;
      end
   end

   assign Time_DatOut = r_result;

endmodule
`default_nettype wire

// File: rtl/pps_slave_timestamper.sv
`default_nettype none
//==============================================================================
// pps_slave_timestamper : PPS edge timestamping with delay compensation, width and timeout
// Revision: 1.0
//==============================================================================
module pps_slave_timestamper
   import pps_slave_timestamper_pkg::*;
#(
   parameter int ClockPeriod_Gen   = 20,
   parameter int SyncStages_Gen    = 2,
   parameter int InputDelay_Gen    = 0,
   parameter int TimeoutCycles_Gen = 75000000
)(
   input  logic        SysClk_ClkIn,
   input  logic        SysRst_RstIn,
   input  logic [31:0] ClockTime_Second_DatIn,
   input  logic [31:0] ClockTime_Nanosecond_DatIn,
   input  logic        ClockTime_TimeJump_DatIn,
   input  logic        ClockTime_ValIn,
   input  logic        Pps_EvtIn,
   input  logic        Enable_EnaIn,
   input  logic        Polarity_DatIn,
   input  logic [15:0] CableDelay_DatIn,
   output logic        Timestamp_ValOut,
   input  logic        Timestamp_RdyIn,
   output logic [31:0] Timestamp_Second_DatOut,
   output logic [31:0] Timestamp_Nanosecond_DatOut,
   output logic [31:0] PulseWidth_DatOut,
   output logic        Overflow_ErrOut,
   output logic        Invalid_ErrOut,
   output logic        Missing_ErrOut
);

   localparam int          c_fixedDelay  = (SyncStages_Gen + 1) * ClockPeriod_Gen + InputDelay_Gen;
   localparam logic [31:0] c_timeoutLast = 32'(TimeoutCycles_Gen - 1);

   generate
      if (SyncStages_Gen < 2) begin : g_syncDepthCheck
         $error("SyncStages_Gen must be at least 2");
      end
      if (longint'(c_fixedDelay) + 65535 >= longint'(NanosInSecond_Con)) begin : g_delayCheck
         $error("worst-case compensation delay must stay below one second");
      end
   endgenerate

   logic [SyncStages_Gen-1:0] r_sync;
   logic                      r_hist;
   logic                      w_active;
   logic                      w_edge;
   logic                      w_armed;
   logic                      w_timeOk;
   PpsState_Type              r_state;
   PpsState_Type              w_nextState;
   logic                      r_capVal;
   ClockTime_Type             r_capTime;
   logic [31:0]               r_capDelay;
   ClockTime_Type             w_slotTime;
   logic                      w_consume;
   logic                      w_load;
   logic                      r_valOut;
   logic                      r_overflow;
   logic                      r_invalid;
   logic                      r_missing;
   logic [31:0]               r_timeoutCnt;
   logic [31:0]               r_widthCnt;
   logic [31:0]               r_pulseWidth;

   assign w_active  = (r_sync[SyncStages_Gen-1] == Polarity_DatIn);
   assign w_edge    = w_active && (r_hist != Polarity_DatIn);
   // Idle blocks capture so an edge coinciding with Enable rising is ignored.
   assign w_armed   = Enable_EnaIn && (r_state != Idle_St);
   assign w_timeOk  = ClockTime_ValIn && !ClockTime_TimeJump_DatIn;
   assign w_consume = r_valOut && Timestamp_RdyIn;
   assign w_load    = r_capVal && (!r_valOut || w_consume);

   always_ff @(posedge SysClk_ClkIn) begin
      if (SysRst_RstIn) begin
         r_sync     <= '0;
         r_hist     <= 1'b0;
         r_capVal   <= 1'b0;
         r_capTime  <= '0;
         r_capDelay <= '0;
         r_valOut   <= 1'b0;
         r_overflow <= 1'b0;
         r_invalid  <= 1'b0;
      end else begin
         r_sync     <= {r_sync[SyncStages_Gen-2:0], Pps_EvtIn};
         r_hist     <= r_sync[SyncStages_Gen-1];
         r_capVal   <= w_edge && w_armed && w_timeOk;
         r_invalid  <= w_edge && w_armed && !w_timeOk;
         if (w_edge && w_armed && w_timeOk) begin
            r_capTime.second     <= ClockTime_Second_DatIn;
            r_capTime.nanosecond <= ClockTime_Nanosecond_DatIn;
            r_capDelay           <= 32'(c_fixedDelay) + {16'd0, CableDelay_DatIn};
         end
         r_valOut   <= w_load || (r_valOut && !w_consume);
         r_overflow <= r_capVal && r_valOut && !w_consume;
      end
   end

   // The subtractor's result register doubles as the output slot.
   pps_time_subtract u_subtract (
      .SysClk_ClkIn (SysClk_ClkIn),
      .SysRst_RstIn (SysRst_RstIn),
      .Load_EnaIn   (w_load),
      .Time_DatIn   (r_capTime),
      .Delay_DatIn  (r_capDelay),
      .Time_DatOut  (w_slotTime)
   );

   always_ff @(posedge SysClk_ClkIn) begin
      if (SysRst_RstIn) begin
         r_state <= Idle_St;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         Idle_St:     if (Enable_EnaIn) w_nextState = WaitEdge_St;
         WaitEdge_St: if (w_edge)       w_nextState = High_St;
         High_St:     if (!w_active)    w_nextState = WaitEdge_St;
         default:                       w_nextState = Idle_St;
      endcase
      if (!Enable_EnaIn) begin
         w_nextState = Idle_St;
      end
   end

   always_ff @(posedge SysClk_ClkIn) begin
      if (SysRst_RstIn) begin
         r_timeoutCnt <= '0;
         r_missing    <= 1'b0;
         r_widthCnt   <= '0;
         r_pulseWidth <= '0;
      end else begin
         if (r_state == Idle_St || !Enable_EnaIn) begin
            r_timeoutCnt <= '0;
            r_missing    <= 1'b0;
         end else if (r_state == WaitEdge_St && w_edge) begin
            r_timeoutCnt <= '0;
            r_missing    <= 1'b0;
         end else if (r_timeoutCnt == c_timeoutLast) begin
            r_missing    <= 1'b1;
         end else begin
            r_timeoutCnt <= r_timeoutCnt + 32'd1;
         end
         // The edge cycle is the first active cycle of the pulse.
         if (r_state == WaitEdge_St && w_edge) begin
            r_widthCnt <= 32'd1;
         end else if (r_state == High_St && w_active) begin
            r_widthCnt <= r_widthCnt + 32'd1;
         end
         if (r_state == High_St && !w_active && Enable_EnaIn) begin
            r_pulseWidth <= r_widthCnt;
         end
      end
   end

   assign Timestamp_ValOut            = r_valOut;
   assign Timestamp_Second_DatOut     = w_slotTime.second;
   assign Timestamp_Nanosecond_DatOut = w_slotTime.nanosecond;
   assign PulseWidth_DatOut           = r_pulseWidth;
   assign Overflow_ErrOut             = r_overflow;
   assign Invalid_ErrOut              = r_invalid;
   assign Missing_ErrOut              = r_missing;

endmodule
`default_nettype wire

// File: tb/tb_pps_slave_timestamper.sv
`default_nettype none
//==============================================================================
// tb_pps_slave_timestamper : randomized scoreboard bench for pps_slave_timestamper
// Revision: 1.0
//==============================================================================
module tb_pps_slave_timestamper;

   localparam int periodNs   = 20;
   localparam int syncStages = 2;
   localparam int inputDelay = 0;
   localparam int timeoutCyc = 1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ctSec = '0;
   logic [31:0] ctNs = '0;
   logic        ctJump = 1'b0;
   logic        ctVal = 1'b1;
   logic        pps = 1'b0;
   logic        en = 1'b0;
   logic        pol = 1'b1;
   logic [15:0] cable = '0;
   logic        rdy = 1'b0;
   logic        valOut;
   logic [31:0] tsSec;
   logic [31:0] tsNs;
   logic [31:0] width;
   logic        ovf;
   logic        inv;
   logic        miss;

   int          checks = 0;
   int          errors = 0;
   int          ovCnt = 0;
   int          invCnt = 0;
   int          expOv = 0;
   int          expInv = 0;
   bit          rdyRandom = 1'b0;
   logic [63:0] expQ[$];

   always #(periodNs / 2) clk = ~clk;

   pps_slave_timestamper #(
      .ClockPeriod_Gen   (periodNs),
      .SyncStages_Gen    (syncStages),
      .InputDelay_Gen    (inputDelay),
      .TimeoutCycles_Gen (timeoutCyc)
   ) dut (
      .SysClk_ClkIn                (clk),
      .SysRst_RstIn                (rst),
      .ClockTime_Second_DatIn      (ctSec),
      .ClockTime_Nanosecond_DatIn  (ctNs),
      .ClockTime_TimeJump_DatIn    (ctJump),
      .ClockTime_ValIn             (ctVal),
      .Pps_EvtIn                   (pps),
      .Enable_EnaIn                (en),
      .Polarity_DatIn              (pol),
      .CableDelay_DatIn            (cable),
      .Timestamp_ValOut            (valOut),
      .Timestamp_RdyIn             (rdy),
      .Timestamp_Second_DatOut     (tsSec),
      .Timestamp_Nanosecond_DatOut (tsNs),
      .PulseWidth_DatOut           (width),
      .Overflow_ErrOut             (ovf),
      .Invalid_ErrOut              (inv),
      .Missing_ErrOut              (miss)
   );

   // Reference: edge time minus total delay, borrowing one second when needed.
   function automatic logic [63:0] expTs(input logic [31:0] s, input logic [31:0] n, input logic [15:0] c);
      longint      d;
      longint      nn;
      logic [31:0] s1;
      d  = longint'((syncStages + 1) * periodNs + inputDelay) + longint'(c);
      nn = longint'(n);
      if (nn >= d) return {s, 32'(nn - d)};
      s1 = s - 32'd1;
      return {s1, 32'(nn + 64'd1000000000 - d)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      if (rdyRandom) rdy = 1'($urandom_range(0, 1));
   endtask

   task automatic setTime(input logic [31:0] s, input logic [31:0] n, input logic v, input logic j,
                          input logic [15:0] c);
      ctSec = s; ctNs = n; ctVal = v; ctJump = j; cable = c;
   endtask

   task automatic pulse(input int w, input bit consumeAtLoad, input bit chkLat);
      pps = pol;
      for (int i = 1; i <= w; i++) begin
         tick();
         if (consumeAtLoad && i == 3) rdy = 1'b1;
         if (chkLat && i == 3) chk("latency_early", 64'(valOut), 64'd0);
         if (chkLat && i == 4) chk("latency", 64'(valOut), 64'd1);
      end
      pps = ~pol;
   endtask

   task automatic drain();
      rdy = 1'b1;
      repeat (8) tick();
      for (int i = 0; i < 200 && expQ.size() > 0; i++) begin
         rdy = 1'b1;
         tick();
      end
      chk("drain", 64'(expQ.size()), 64'd0);
   endtask

   task automatic setPol(input logic p);
      en  = 1'b0;
      pol = p;
      pps = ~p;
      repeat (5) tick();
      en = 1'b1;
      repeat (3) tick();
   endtask

   initial begin
      fork
         begin : monitor
            bit          held = 1'b0;
            logic [63:0] prevTs = '0;
            forever begin
               @(negedge clk);
               if (rst) begin
                  held = 1'b0;
               end else begin
                  if (held) chk("hold_stable", {31'd0, valOut, tsSec[31:0]} ^ {32'd0, tsNs} ^ 64'd0 ^ {32'd0, tsNs},
                               {31'd0, 1'b1, prevTs[63:32]});
                  if (held) chk("hold_ns", 64'(tsNs), 64'(prevTs[31:0]));
                  if (valOut && rdy) begin
                     if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ts actual=%0h required=none", {tsSec, tsNs});
                     end else begin
                        chk("timestamp", {tsSec, tsNs}, expQ.pop_front());
                     end
                  end
                  held   = valOut && !rdy;
                  prevTs = {tsSec, tsNs};
                  if (ovf) ovCnt++;
                  if (inv) invCnt++;
               end
            end
         end
      join_none

      repeat (3) tick();
      chk("reset_flags", {60'd0, valOut, ovf, inv, miss}, 64'd0);
      chk("reset_ts", {tsSec, tsNs}, 64'd0);
      chk("reset_width", 64'(width), 64'd0);
      rst = 1'b0;
      en  = 1'b1;
      repeat (5) tick();

      // Clean edge with latency check, then borrow cases.
      setTime(32'd10, 32'd500000000, 1'b1, 1'b0, 16'd100);
      expQ.push_back(expTs(32'd10, 32'd500000000, 16'd100));
      pulse(6, 1'b0, 1'b1);
      drain();
      setTime(32'd10, 32'd50, 1'b1, 1'b0, 16'd100);
      expQ.push_back(expTs(32'd10, 32'd50, 16'd100));
      rdy = 1'b0;
      pulse(5, 1'b0, 1'b0);
      drain();
      setTime(32'd0, 32'd50, 1'b1, 1'b0, 16'd100);
      expQ.push_back(expTs(32'd0, 32'd50, 16'd100));
      pulse(5, 1'b0, 1'b0);
      drain();

      // Backpressure: second result dropped.
      rdy = 1'b0;
      setTime(32'd100, 32'd123456789, 1'b1, 1'b0, 16'd7);
      expQ.push_back(expTs(32'd100, 32'd123456789, 16'd7));
      pulse(5, 1'b0, 1'b0);
      repeat (8) tick();
      setTime(32'd101, 32'd123456789, 1'b1, 1'b0, 16'd7);
      expOv++;
      pulse(5, 1'b0, 1'b0);
      repeat (8) tick();
      chk("overflow_held", 64'(valOut), 64'd1);
      chk("overflow_pulse", 64'(ovCnt), 64'(expOv));
      drain();

      // Consume in the same cycle the second result lands.
      rdy = 1'b0;
      setTime(32'd200, 32'd999999999, 1'b1, 1'b0, 16'd65535);
      expQ.push_back(expTs(32'd200, 32'd999999999, 16'd65535));
      pulse(5, 1'b0, 1'b0);
      repeat (8) tick();
      setTime(32'd201, 32'd999999999, 1'b1, 1'b0, 16'd65535);
      expQ.push_back(expTs(32'd201, 32'd999999999, 16'd65535));
      pulse(6, 1'b1, 1'b0);
      repeat (8) tick();
      chk("no_overflow", 64'(ovCnt), 64'(expOv));
      drain();

      // Invalid time: no capture, error pulse.
      setTime(32'd300, 32'd1000, 1'b0, 1'b0, 16'd0);
      expInv++;
      pulse(5, 1'b0, 1'b0);
      repeat (8) tick();
      chk("invalid_noval", 64'(valOut), 64'd0);
      chk("invalid_val", 64'(invCnt), 64'(expInv));
      setTime(32'd301, 32'd1000, 1'b1, 1'b1, 16'd0);
      expInv++;
      pulse(5, 1'b0, 1'b0);
      repeat (8) tick();
      chk("invalid_jump", 64'(invCnt), 64'(expInv));

      // 100-cycle pulse width.
      setTime(32'd400, 32'd777, 1'b1, 1'b0, 16'd3);
      expQ.push_back(expTs(32'd400, 32'd777, 16'd3));
      pulse(100, 1'b0, 1'b0);
      repeat (8) tick();
      chk("width100", 64'(width), 64'd100);
      drain();

      // Falling-edge polarity.
      setPol(1'b0);
      setTime(32'd500, 32'd42, 1'b1, 1'b0, 16'd11);
      expQ.push_back(expTs(32'd500, 32'd42, 16'd11));
      pulse(12, 1'b0, 1'b0);
      repeat (8) tick();
      chk("width_falling", 64'(width), 64'd12);
      drain();
      setPol(1'b1);

      // Enable low suppresses capture.
      en = 1'b0;
      repeat (3) tick();
      setTime(32'd600, 32'd5, 1'b1, 1'b0, 16'd0);
      pulse(5, 1'b0, 1'b0);
      repeat (8) tick();
      chk("disabled_noval", 64'(valOut), 64'd0);
      chk("disabled_noinv", 64'(invCnt), 64'(expInv));
      chk("disabled_nomiss", 64'(miss), 64'd0);

      // Missing-pulse timeout.
      en = 1'b1;
      repeat (990) tick();
      chk("missing_early", 64'(miss), 64'd0);
      repeat (20) tick();
      chk("missing_set", 64'(miss), 64'd1);
      setTime(32'd700, 32'd900000000, 1'b1, 1'b0, 16'd0);
      expQ.push_back(expTs(32'd700, 32'd900000000, 16'd0));
      pulse(5, 1'b0, 1'b0);
      chk("missing_clear_edge", 64'(miss), 64'd0);
      drain();
      repeat (1010) tick();
      chk("missing_again", 64'(miss), 64'd1);
      en = 1'b0;
      repeat (2) tick();
      chk("missing_clear_en", 64'(miss), 64'd0);
      en = 1'b1;
      repeat (3) tick();

      // Randomized edges, polarities, delays and validity.
      rdyRandom = 1'b1;
      for (int it = 0; it < 20; it++) begin
         logic [31:0] s;
         logic [31:0] n;
         logic [15:0] c;
         int          kind;
         int          w;
         s    = $urandom;
         n    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom_range(0, 999999999));
         c    = 16'($urandom_range(0, 65535));
         kind = $urandom_range(0, 5);
         w    = $urandom_range(4, 30);
         if ($urandom_range(0, 3) == 0) setPol(~pol);
         if (kind == 0)      begin setTime(s, n, 1'b0, 1'b0, c); expInv++; end
         else if (kind == 1) begin setTime(s, n, 1'b1, 1'b1, c); expInv++; end
         else begin
            setTime(s, n, 1'b1, 1'b0, c);
            expQ.push_back(expTs(s, n, c));
         end
         pulse(w, 1'b0, 1'b0);
         repeat (8) tick();
         chk("width_rand", 64'(width), 64'(w));
         for (int i = 0; i < 200 && expQ.size() > 0; i++) tick();
         chk("rand_drained", 64'(expQ.size()), 64'd0);
      end
      rdyRandom = 1'b0;
      setPol(1'b1);

      // Reset while a timestamp is pending.
      rdy = 1'b0;
      setTime(32'd800, 32'd1234, 1'b1, 1'b0, 16'd9);
      expQ.push_back(expTs(32'd800, 32'd1234, 16'd9));
      pulse(5, 1'b0, 1'b0);
      repeat (3) tick();
      chk("pending_before_rst", 64'(valOut), 64'd1);
      rst = 1'b1;
      expQ.delete();
      tick();
      chk("rst_flags", {60'd0, valOut, ovf, inv, miss}, 64'd0);
      chk("rst_ts", {tsSec, tsNs}, 64'd0);
      chk("rst_width", 64'(width), 64'd0);
      rst = 1'b0;
      repeat (5) tick();

      chk("overflow_total", 64'(ovCnt), 64'(expOv));
      chk("invalid_total", 64'(invCnt), 64'(expInv));
      chk("queue_empty", 64'(expQ.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
